// File: rtl/keypad_encoder_if.sv
// Character stream in, phone-keypad press/confirm pulses out.
interface keypad_encoder_if;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;
  logic [7:0] btn;
  logic       btn_confirm;
  logic       busy;
  logic       char_done;
  logic       err;

  modport master (
    output ascii_in, ascii_valid,
    input  ascii_ready, btn, btn_confirm, busy, char_done, err
  );

  modport slave (
    input  ascii_in, ascii_valid,
    output ascii_ready, btn, btn_confirm, busy, char_done, err
  );
endinterface

// File: rtl/keypad_encoder.sv
// Encodes ASCII letters into multi-tap phone keypad presses (keys 2..9) followed
// by a confirm pulse; a 4-entry FIFO buffers incoming characters.
module keypad_encoder #(
  parameter int unsigned PRESS_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input logic            clk,
  input logic            rst,
  keypad_encoder_if.slave kif
);

  typedef enum logic [2:0] {IDLE, LOAD, PRESS, GAP, CONF, CGAP} state_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] key;
    logic [2:0] cnt;
  } key_code_t;

  localparam logic [15:0] PRESS_LOAD = 16'(PRESS_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD   = 16'(GAP_CYCLES - 1);

  function automatic logic [7:0] upcase(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  function automatic logic encodable(input logic [7:0] c);
    logic [7:0] u;
    u = upcase(c);
    return (u >= 8'h41 && u <= 8'h5A);
  endfunction

  // Groups are three letters wide except PQRS and WXYZ.
  function automatic key_code_t decode(input logic [7:0] c);
    key_code_t  r;
    logic [4:0] off;
    r   = '0;
    off = 5'(upcase(c) - 8'h41);
    if (encodable(c)) begin
      r.ok = 1'b1;
      if (off < 5'd15) begin
        r.key = 3'(off / 5'd3);
        r.cnt = 3'(off % 5'd3 + 5'd1);
      end else if (off < 5'd19) begin
        r.key = 3'd5;
        r.cnt = 3'(off - 5'd14);
      end else if (off < 5'd22) begin
        r.key = 3'd6;
        r.cnt = 3'(off - 5'd18);
      end else begin
        r.key = 3'd7;
        r.cnt = 3'(off - 5'd21);
      end
    end
    return r;
  endfunction

  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;

  state_t     state;
  logic [15:0] phase;
  logic [2:0] presses;
  logic [2:0] key;
  logic [7:0] cur_char;
  key_code_t  cur_code;
  logic [7:0] btn_q;
  logic       confirm_q;
  logic       done_q;
  logic       err_q;

  assign push     = kif.ascii_valid && kif.ascii_ready;
  assign pop      = (state == IDLE) && (count != 3'd0);
  assign cur_code = decode(cur_char);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= kif.ascii_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      presses   <= '0;
      key       <= '0;
      cur_char  <= '0;
      btn_q     <= '0;
      confirm_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            cur_char <= mem[rd_ptr];
            // err is registered, so it is raised here to be visible during LOAD
            err_q    <= !encodable(mem[rd_ptr]);
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (cur_code.ok) begin
            key     <= cur_code.key;
            presses <= cur_code.cnt;
            btn_q   <= 8'd1 << cur_code.key;
            phase   <= PRESS_LOAD;
            state   <= PRESS;
          end else begin
            state <= IDLE;
          end
        end
        PRESS: begin
          if (phase == '0) begin
            btn_q <= '0;
            phase <= GAP_LOAD;
            state <= GAP;
          end else begin
            phase <= phase - 16'd1;
          end
        end
        GAP: begin
          if (phase == '0) begin
            phase <= PRESS_LOAD;
            if (presses > 3'd1) begin
              presses <= presses - 3'd1;
              btn_q   <= 8'd1 << key;
              state   <= PRESS;
            end else begin
              presses   <= '0;
              confirm_q <= 1'b1;
              state     <= CONF;
            end
          end else begin
            phase <= phase - 16'd1;
          end
        end
        CONF: begin
          if (phase == '0) begin
            confirm_q <= 1'b0;
            phase     <= GAP_LOAD;
            // a single-cycle CGAP is also its last cycle
            done_q    <= (GAP_LOAD == '0);
            state     <= CGAP;
          end else begin
            phase <= phase - 16'd1;
          end
        end
        CGAP: begin
          if (phase == '0) begin
            state <= IDLE;
          end else begin
            done_q <= (phase == 16'd1);
            phase  <= phase - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kif.ascii_ready = (count != 3'd4);
  assign kif.busy        = (state != IDLE) || (count != 3'd0);
  assign kif.btn         = btn_q;
  assign kif.btn_confirm = confirm_q;
  assign kif.char_done   = done_q;
  assign kif.err         = err_q;

endmodule
